// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: bundles the requester handshake and the SRAM wrapper pins
// of sram_port_arbiter.
//
// Signals (arbiter view, modport slave):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  in   requests from port 0 / port 1
//   done0/done1                                     out  one-cycle completion pulses
//   rdata                                           out  registered read data
//   busy                                            out  access in flight
//   sram_read_enable/sram_write_enable              out  wrapper enables
//   sram_address/sram_write_data                    out  wrapper address and write data
//   sram_read_data                                  in   wrapper read data
// The master modport is the mirror image, used by whatever plays both requesters
// and the SRAM wrapper.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              sram_read_enable;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;
  logic [DATA_W-1:0] sram_read_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_read_data,
    output done0, done1, rdata, busy,
    output sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_read_data,
    input  done0, done1, rdata, busy,
    input  sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the single-port SRAM wrapper between port 0 (moving-average
// engine) and port 1 (host/debug reader). Each granted access runs IDLE -> GRANT (address
// setup) -> ACCESS (enables held ACCESS_CYCLES cycles) -> DONE (one-cycle done pulse).
//
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    sram_port_arbiter_if.slave: requester handshake, rdata, busy and SRAM pins
//
// Parameters: ADDR_W, DATA_W (must match the interface instance), ACCESS_CYCLES (1..15).
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN to make port 0 always win contention
// (port 1 may starve); otherwise contention is resolved round robin.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic                 clk,
  input logic                 n_rst,
  sram_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StAccess, StDone} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       sel_q;
  logic       lat_we_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic       last_grant_q;
`endif

  // Winner of the current IDLE cycle and its request fields.
  logic              pick;
  logic              we_pick;
  logic [ADDR_W-1:0] addr_pick;
  logic [DATA_W-1:0] wdata_pick;

  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = ~last_grant_q;
`endif
    end else if (bus.req1) begin
      pick = 1'b1;
    end
    we_pick    = pick ? bus.we1    : bus.we0;
    addr_pick  = pick ? bus.addr1  : bus.addr0;
    wdata_pick = pick ? bus.wdata1 : bus.wdata0;
  end

  // The sram_address / sram_write_data registers double as the latched request fields:
  // they are loaded at grant and held untouched until the access ends.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q               <= StIdle;
      cnt_q                 <= '0;
      sel_q                 <= 1'b0;
      lat_we_q              <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant_q          <= 1'b1;  // port 0 wins the first contention
`endif
      bus.done0             <= 1'b0;
      bus.done1             <= 1'b0;
      bus.rdata             <= '0;
      bus.busy              <= 1'b0;
      bus.sram_read_enable  <= 1'b0;
      bus.sram_write_enable <= 1'b0;
      bus.sram_address      <= '0;
      bus.sram_write_data   <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            sel_q               <= pick;
            lat_we_q            <= we_pick;
            bus.sram_address    <= addr_pick;
            bus.sram_write_data <= wdata_pick;
            bus.busy            <= 1'b1;
            state_q             <= StGrant;
          end
        end
        StGrant: begin
          cnt_q                 <= '0;
          bus.sram_write_enable <= lat_we_q;
          bus.sram_read_enable  <= ~lat_we_q;
          state_q               <= StAccess;
        end
        StAccess: begin
          if (cnt_q == LastCnt) begin
            if (!lat_we_q) begin
              bus.rdata <= bus.sram_read_data;
            end
            bus.sram_write_enable <= 1'b0;
            bus.sram_read_enable  <= 1'b0;
            bus.sram_address      <= '0;
            bus.sram_write_data   <= '0;
            bus.done0             <= ~sel_q;
            bus.done1             <= sel_q;
            state_q               <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
          last_grant_q <= sel_q;
`endif
          bus.busy     <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter with a small
// behavioural SRAM model (read data registered one cycle after read_enable).
module tb_sram_port_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic n_rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (bus.sram_write_enable) mem[bus.sram_address[7:0]] <= bus.sram_write_data;
    if (bus.sram_read_enable)  bus.sram_read_data <= mem[bus.sram_address[7:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  // Runs one access from IDLE and reports what it saw; inputs are scrambled after the
  // grant cycle so any use of unlatched fields shows up as a bad address/data cycle.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int done_cyc, output int re_cyc,
                        output int we_cyc, output int bad, output int wrong_done);
    done_cyc = -1; re_cyc = 0; we_cyc = 0; bad = 0; wrong_done = 0;
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        bus.addr0 = ~addr; bus.wdata0 = ~wd; bus.we0 = ~we;
        bus.addr1 = ~addr; bus.wdata1 = ~wd; bus.we1 = ~we;
      end
      if (bus.sram_read_enable) re_cyc++;
      if (bus.sram_write_enable) begin
        we_cyc++;
        if (bus.sram_write_data !== wd) bad++;
      end
      if ((bus.sram_read_enable || bus.sram_write_enable) && bus.sram_address !== addr) bad++;
      if ((port ? bus.done0 : bus.done1) === 1'b1) wrong_done++;
      if ((port ? bus.done1 : bus.done0) === 1'b1) begin
        done_cyc = c;
        idle_inputs();
        step();
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.done0, bus.done1, bus.busy, bus.sram_read_enable, bus.sram_write_enable} !== 5'b0)
      begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {bus.done0, bus.done1,
        bus.busy, bus.sram_read_enable, bus.sram_write_enable}); end
    tests++;
    if (bus.rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    tests++;
    if (bus.sram_address !== '0)
      begin fails++; $display("FAIL reset_addr: got %h want 0", bus.sram_address); end
    tests++;
    if (bus.sram_write_data !== '0)
      begin fails++; $display("FAIL reset_wdata: got %h want 0", bus.sram_write_data); end
  endtask

  task automatic test_port1_write_read();
    int d, r, w, b, x;
    access(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, d, r, w, b, x);
    tests++; if (d !== 4) begin fails++; $display("FAIL p1_wr_done: got %0d want 4", d); end
    tests++; if (w !== 2) begin fails++; $display("FAIL p1_wr_we_cycles: got %0d want 2", w); end
    tests++; if (r !== 0) begin fails++; $display("FAIL p1_wr_re_cycles: got %0d want 0", r); end
    tests++; if (b !== 0) begin fails++; $display("FAIL p1_wr_addr_data: got %0d bad want 0", b); end
    tests++; if (x !== 0) begin fails++; $display("FAIL p1_wr_done0: got %0d want 0", x); end
    access(1'b1, 1'b0, 16'h0010, 32'h0, d, r, w, b, x);
    tests++; if (d !== 4) begin fails++; $display("FAIL p1_rd_done: got %0d want 4", d); end
    tests++; if (r !== 2) begin fails++; $display("FAIL p1_rd_re_cycles: got %0d want 2", r); end
    tests++; if (w !== 0) begin fails++; $display("FAIL p1_rd_we_cycles: got %0d want 0", w); end
    tests++;
    if (bus.rdata !== 32'hDEADBEEF)
      begin fails++; $display("FAIL p1_rd_data: got %h want deadbeef", bus.rdata); end
  endtask

  task automatic test_port0_read_latency();
    int d, r, w, b, x;
    access(1'b0, 1'b1, 16'd252, 32'h12345678, d, r, w, b, x);
    tests++; if (d !== 4) begin fails++; $display("FAIL p0_wr_done: got %0d want 4", d); end
    access(1'b0, 1'b0, 16'd252, 32'h0, d, r, w, b, x);
    tests++; if (d !== 4) begin fails++; $display("FAIL p0_rd_latency: got %0d want 4", d); end
    tests++; if (r !== 2) begin fails++; $display("FAIL p0_rd_re_cycles: got %0d want 2", r); end
    tests++; if (b !== 0) begin fails++; $display("FAIL p0_rd_addr: got %0d bad want 0", b); end
    tests++; if (x !== 0) begin fails++; $display("FAIL p0_rd_done1: got %0d want 0", x); end
    tests++;
    if (bus.rdata !== 32'h12345678)
      begin fails++; $display("FAIL p0_rd_data: got %h want 12345678", bus.rdata); end
  endtask

  task automatic test_contention();
    int d0 = -1, d1 = -1;
    logic busy5 = 1'b1, en6 = 1'b1;
    logic [AW-1:0] addr6 = '0;
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0040; bus.wdata0 = 32'h0000000A;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0044; bus.wdata1 = 32'h0000000B;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 5) busy5 = bus.busy;
      if (c == 6) begin addr6 = bus.sram_address; en6 = bus.sram_read_enable | bus.sram_write_enable; end
      if (bus.done0 === 1'b1) begin d0 = c; bus.req0 = 1'b0; end
      if (bus.done1 === 1'b1) begin d1 = c; bus.req1 = 1'b0; break; end
    end
    idle_inputs();
    step();
    tests++; if (d0 !== 4) begin fails++; $display("FAIL cont_done0: got %0d want 4", d0); end
    tests++; if (d1 !== 9) begin fails++; $display("FAIL cont_done1: got %0d want 9", d1); end
    tests++; if (busy5 !== 1'b0) begin fails++; $display("FAIL cont_idle_busy: got %b want 0", busy5); end
    tests++;
    if (addr6 !== 16'h0044) begin fails++; $display("FAIL cont_grant_addr: got %h want 0044", addr6); end
    tests++; if (en6 !== 1'b0) begin fails++; $display("FAIL cont_grant_en: got %b want 0", en6); end
  endtask

  task automatic test_alternate();
    int n = 0, overlap = 0, both_en = 0;
    bit seq [5];
    bit exp [4];
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0080; bus.wdata0 = 32'h000000C0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0084; bus.wdata1 = 32'h000000C1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (bus.done0 && bus.done1) overlap++;
      if (bus.sram_read_enable && bus.sram_write_enable) both_en++;
      if (bus.done0 || bus.done1) begin
        seq[n] = bus.done1;
        n++;
        if (n == 4) bus.req0 = 1'b0;
        if (n == 5) break;
      end
    end
    idle_inputs();
    step();
    tests++; if (n !== 5) begin fails++; $display("FAIL alt_count: got %0d want 5", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (seq[i] !== exp[i])
        begin fails++; $display("FAIL alt_order[%0d]: got port %0d want port %0d", i, seq[i], exp[i]); end
    end
    tests++;
    if (seq[4] !== 1'b1) begin fails++; $display("FAIL alt_after_drop: got port %0d want 1", seq[4]); end
    tests++; if (overlap !== 0) begin fails++; $display("FAIL alt_done_overlap: got %0d want 0", overlap); end
    tests++; if (both_en !== 0) begin fails++; $display("FAIL alt_both_en: got %0d want 0", both_en); end
  endtask

  task automatic test_reset_mid();
    int d, r, w, b, x;
    int stray = 0;
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0020; bus.wdata1 = 32'h55AA55AA;
    step(); step(); step();  // GRANT, ACCESS 1, ACCESS 2
    tests++;
    if (bus.sram_write_enable !== 1'b1)
      begin fails++; $display("FAIL rmid_pre_we: got %b want 1", bus.sram_write_enable); end
    n_rst = 1'b0;
    #1;
    tests++;
    if ({bus.done0, bus.done1, bus.busy, bus.sram_read_enable, bus.sram_write_enable} !== 5'b0)
      begin fails++; $display("FAIL rmid_ctrl: got %b want 00000", {bus.done0, bus.done1,
        bus.busy, bus.sram_read_enable, bus.sram_write_enable}); end
    tests++;
    if (bus.sram_address !== '0 || bus.sram_write_data !== '0 || bus.rdata !== '0)
      begin fails++; $display("FAIL rmid_data: got addr %h wdata %h rdata %h want 0", bus.sram_address,
        bus.sram_write_data, bus.rdata); end
    idle_inputs();
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.done0 || bus.done1 || bus.busy) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL rmid_stray: got %0d want 0", stray); end
    access(1'b1, 1'b0, 16'h0010, 32'h0, d, r, w, b, x);
    tests++; if (d !== 4) begin fails++; $display("FAIL rmid_after_done: got %0d want 4", d); end
    tests++; if (r !== 2) begin fails++; $display("FAIL rmid_after_re: got %0d want 2", r); end
    tests++;
    if (bus.rdata !== 32'hDEADBEEF)
      begin fails++; $display("FAIL rmid_after_data: got %h want deadbeef", bus.rdata); end
  endtask

  initial begin
    n_rst = 1'b0;
    idle_inputs();
    test_reset();
    test_port1_write_read();
    test_port0_read_latency();
    test_contention();
    test_alternate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
